hadamard_sched: RTL and testbench
=================================

HADAMARD_SCHED -- requirements
Module: hadamard_sched

Parameters
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- formatWidth  9  width of one SFP word.
- LATENCY  5  register stages in the complexhadamard core.
- NUM_GROUPS  4  4-point groups per frame.
- FIFO_DEPTH  8  depth of the output buffer; must be ≥ LATENCY+1.

Interface
REQ-002 SHALL list ports, one per line: name  direction  width  meaning. Clock and reset come first.
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high).
- start  in  1  frame start pulse.
- in_valid / in_ready  in/out  1/1  upstream group handshake.
- in_real, in_imag  in  formatWidth*4  four complex inputs.
- tw_addr  out  log2(NUM_GROUPS)  twiddle ROM address (the current group index).
- tw_real, tw_imag  in  formatWidth*4  twiddles for tw_addr, combinational.
- core_rst_n  out  1  active-low reset to the core, equal to ~rst.
- core_in_real, core_in_imag, core_tw_real, core_tw_imag  out  formatWidth*4  registered core operands.
- core_out_real, core_out_imag  in  formatWidth*4  core results.
- out_valid / out_ready  out/in  1/1  downstream handshake.
- out_real, out_imag  out  formatWidth*4  result group.
- out_last  out  1  marks the final group of the frame.
- busy  out  1  high when the FSM is not IDLE.
- done  out  1  one-cycle frame-complete pulse.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-004 SHALL go IDLE→ISSUE on start=1, clearing the group counter (grp) to 0. start SHALL be ignored in any other state.
REQ-005 SHALL drive in_ready = (state==ISSUE) && (inflight + fifo_count < FIFO_DEPTH). This is credit-based, because the core has no stall.
REQ-006 SHALL treat an accept as in_valid && in_ready at a rising edge. On each accept:
- register in_real/in_imag/tw_real/tw_imag onto the core_* operand outputs;
- push tag {1, grp==NUM_GROUPS-1} into a LATENCY+1 deep valid shift register;
- increment grp.
REQ-007 SHALL drive core operand outputs to 0 on cycles with no accept, and push tag {0,0}.
REQ-008 SHALL drive tw_addr = grp combinationally.
REQ-009 SHALL go ISSUE→DRAIN at the edge that accepts group NUM_GROUPS-1. grp SHALL wrap to 0.
REQ-010 SHALL, when the shift-register tail tag is valid, write {core_out_real, core_out_imag, last} into the FIFO at that edge. This write lands LATENCY+1 edges after the accept.
REQ-011 SHALL compute inflight as the count of valid tags in the shift register, width log2(LATENCY+2).
REQ-012 SHALL implement the FIFO as FIFO_DEPTH entries with circular read/write pointers, with wrap at FIFO_DEPTH-1.
- out_valid = fifo_count != 0.
- out_real, out_imag and out_last come from the head entry.
- Pop on out_valid && out_ready.
REQ-013 SHALL handle a simultaneous push and pop in one cycle by leaving fifo_count unchanged. A push while full SHALL be impossible by construction (REQ-005); an assertion SHALL flag it.
REQ-014 SHALL go DRAIN→DONE at the edge that pops an entry with last=1.
REQ-015 SHALL assert done=1 for exactly one cycle while in DONE, then return to IDLE.
REQ-016 SHALL give a minimum latency, with out_ready=1 and an empty FIFO, of: accept at edge E → out_valid=1 in the cycle after edge E+LATENCY+1.
REQ-017 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-018 SHALL ignore in_valid in IDLE, DRAIN and DONE (in_ready=0 in those states).

Reset
REQ-019 SHALL, while rst=1, asynchronously clear the following:
- state to IDLE;
- grp, the shift register, and the FIFO pointers and count;
- core operand outputs to 0;
- out_valid, out_last, busy and done to 0.
REQ-020 SHALL, on reset mid-frame, discard all in-flight and buffered groups with no done pulse. core_rst_n SHALL follow ~rst so the core clears at the same time.

Verification
REQ-021 The bench SHALL cover these scenarios:
- V1: start, 4 back-to-back groups, out_ready=1 → out_valid first at 6 cycles after the first accept; 4 consecutive outputs; out_last on the 4th; done 1 cycle after the 4th pop.
- V2: out_ready=0 throughout, 4 groups → all accepted (4 < 8); 4 entries held; out_real unchanged across the stall; releasing out_ready drains them in order.
- V3: NUM_GROUPS=16, out_ready=0 → in_ready drops once inflight+fifo_count=8; exactly 8 accepted; resumes one accept per pop.
- V4: start pulsed during ISSUE and again during DRAIN → grp not reset; total outputs = NUM_GROUPS; one done.
- V5: rst=1 asserted after the 2nd accept → busy, out_valid and done go to 0 immediately; after release and a new start, exactly 4 fresh outputs.
- V6: core model returning core_out_real = core_in_real delayed 5 cycles, with in_real = 0x123456789 → out_real = 0x123456789 at the tagged slot; tw_addr sequence 0,1,2,3.

Source files
------------

// File: rtl/hadamard_sched.sv
// hadamard_sched: frame scheduler feeding a fixed-latency complex Hadamard core, with a credit-limited output FIFO.
module hadamard_sched #(
  parameter int formatWidth = 9,
  parameter int LATENCY     = 5,
  parameter int NUM_GROUPS  = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [formatWidth*4-1:0]              in_real,
  input  logic [formatWidth*4-1:0]              in_imag,
  output logic [$clog2(NUM_GROUPS)-1:0]         tw_addr,
  input  logic [formatWidth*4-1:0]              tw_real,
  input  logic [formatWidth*4-1:0]              tw_imag,
  output logic                                  core_rst_n,
  output logic [formatWidth*4-1:0]              core_in_real,
  output logic [formatWidth*4-1:0]              core_in_imag,
  output logic [formatWidth*4-1:0]              core_tw_real,
  output logic [formatWidth*4-1:0]              core_tw_imag,
  input  logic [formatWidth*4-1:0]              core_out_real,
  input  logic [formatWidth*4-1:0]              core_out_imag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [formatWidth*4-1:0]              out_real,
  output logic [formatWidth*4-1:0]              out_imag,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done
);
  localparam int W   = formatWidth * 4;
  localparam int GW  = $clog2(NUM_GROUPS);
  localparam int CW  = $clog2(LATENCY + 2);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [GW-1:0] grp;
  logic [LATENCY:0] sr_v, sr_l;
  logic [CW-1:0] inflight;
  logic [W-1:0] fr [FIFO_DEPTH];
  logic [W-1:0] fi [FIFO_DEPTH];
  logic fl [FIFO_DEPTH];
  logic [PW-1:0] rp, wp;
  logic [FCW-1:0] fifo_count;
  logic accept, push, pop, last_grp;
  assign accept     = in_valid && in_ready;
  assign push       = sr_v[LATENCY];
  assign pop        = out_valid && out_ready;
  assign last_grp   = grp == GW'(NUM_GROUPS - 1);
  assign tw_addr    = grp;
  assign core_rst_n = ~rst;
  assign out_valid  = fifo_count != '0;
  assign out_real   = fr[rp];
  assign out_imag   = fi[rp];
  assign out_last   = out_valid && fl[rp];
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LATENCY; i++) inflight = inflight + CW'(sr_v[i]);
  end
  // The core cannot stall, so issue only while every in-flight group is guaranteed a FIFO slot.
  assign in_ready = (state == ISSUE) && (int'(inflight) + int'(fifo_count) < FIFO_DEPTH);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grp   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          grp   <= '0;
          busy  <= 1'b1;
        end
        ISSUE: if (accept) begin
          grp <= last_grp ? '0 : grp + GW'(1);
          if (last_grp) state <= DRAIN;
        end
        DRAIN: if (pop && out_last) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_v         <= '0;
      sr_l         <= '0;
      core_in_real <= '0;
      core_in_imag <= '0;
      core_tw_real <= '0;
      core_tw_imag <= '0;
      rp           <= '0;
      wp           <= '0;
      fifo_count   <= '0;
    end else begin
      sr_v         <= {sr_v[LATENCY-1:0], accept};
      sr_l         <= {sr_l[LATENCY-1:0], accept && last_grp};
      core_in_real <= accept ? in_real : '0;
      core_in_imag <= accept ? in_imag : '0;
      core_tw_real <= accept ? tw_real : '0;
      core_tw_imag <= accept ? tw_imag : '0;
      if (push) wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + PW'(1);
      if (pop) rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + PW'(1);
      fifo_count <= fifo_count + FCW'(push) - FCW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fr[wp] <= core_out_real;
      fi[wp] <= core_out_imag;
      fl[wp] <= sr_l[LATENCY];
    end
  end
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_count == FCW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_hadamard_sched.sv
// tb_hadamard_sched: two schedulers (4 and 16 groups per frame) against a queue-based reference and a delay-line core.
module tb_hadamard_sched;
  localparam int W = 36, LAT = 5, FD = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] start = 2'b00;
  logic [W-1:0] in_real = '0, in_imag = '0;
  logic [1:0] in_ready, out_valid, out_last, busy, done, crn;
  logic [1:0] ta0;
  logic [3:0] ta1;
  logic [3:0] ta [2];
  logic [W-1:0] tw_r [2], tw_i [2], cir [2], cii [2], ctr [2], cti [2], cor [2], coi [2], outr [2], outi [2];
  logic [W-1:0] pr [2][LAT], pim [2][LAT];
  int total = 0, bad = 0, cyc = 0;
  int acc [2], pops [2], grpm [2], obs_pops [2], ndone [2], qh [2], qt [2];
  bit active [2], issuing [2], done_exp [2];
  logic [W-1:0] qr [2][16], qi [2][16];
  bit ql [2][16];
  int qa [2][16];
  typedef struct { logic [W-1:0] ir, ii, er, ei; logic el; } vec_t;
  vec_t vt [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] twr(int a);
    return W'(a + 1) * 36'h011111111;
  endfunction
  function automatic logic [W-1:0] twi(int a);
    return 36'h0F0F0F0F0 ^ W'(a);
  endfunction
  function automatic logic [W-1:0] exp_im(logic [W-1:0] im, int a);
    return im + twr(a) + (twi(a) << 1);
  endfunction
  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  assign ta[0] = {2'b00, ta0};
  assign ta[1] = ta1;
  for (genvar g = 0; g < 2; g++) begin : g_core
    assign tw_r[g] = twr(int'(ta[g]));
    assign tw_i[g] = twi(int'(ta[g]));
    assign cor[g]  = pr[g][LAT-1];
    assign coi[g]  = pim[g][LAT-1];
  end

  // Core stand-in: LATENCY register stages; real passes through, imag mixes in both twiddles.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pr[k][0]  <= cir[k];
      pim[k][0] <= cii[k] + ctr[k] + (cti[k] << 1);
      for (int i = 1; i < LAT; i++) begin
        pr[k][i]  <= pr[k][i-1];
        pim[k][i] <= pim[k][i-1];
      end
    end
  end

  hadamard_sched #(.NUM_GROUPS(4)) d0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_real(in_real), .in_imag(in_imag), .tw_addr(ta0), .tw_real(tw_r[0]), .tw_imag(tw_i[0]),
    .core_rst_n(crn[0]), .core_in_real(cir[0]), .core_in_imag(cii[0]), .core_tw_real(ctr[0]),
    .core_tw_imag(cti[0]), .core_out_real(cor[0]), .core_out_imag(coi[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_real(outr[0]), .out_imag(outi[0]), .out_last(out_last[0]),
    .busy(busy[0]), .done(done[0]));
  hadamard_sched #(.NUM_GROUPS(16)) d1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_real(in_real), .in_imag(in_imag), .tw_addr(ta1), .tw_real(tw_r[1]), .tw_imag(tw_i[1]),
    .core_rst_n(crn[1]), .core_in_real(cir[1]), .core_in_imag(cii[1]), .core_tw_real(ctr[1]),
    .core_tw_imag(cti[1]), .core_out_real(cor[1]), .core_out_imag(coi[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_real(outr[1]), .out_imag(outi[1]), .out_last(out_last[1]),
    .busy(busy[1]), .done(done[1]));

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: outstanding = accepted - popped bounds issue; each group appears LATENCY+1 edges after its accept, in order.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int ng, hd;
      bit erdy, eov;
      ng = k ? 16 : 4;
      chk("core_rst_n", W'(crn[k]), W'(!rst));
      if (rst) begin
        chk("rst_state", W'({busy[k], out_valid[k], done[k], in_ready[k]}), '0);
        acc[k] = 0; pops[k] = 0; grpm[k] = 0; qh[k] = 0; qt[k] = 0;
        active[k] = 0; issuing[k] = 0; done_exp[k] = 0;
      end else begin
        hd   = qh[k] % 16;
        erdy = issuing[k] && (acc[k] - pops[k] < FD);
        eov  = (qh[k] != qt[k]) && (cyc >= qa[k][hd] + LAT + 1);
        chk("in_ready", W'(in_ready[k]), W'(erdy));
        chk("out_valid", W'(out_valid[k]), W'(eov));
        chk("busy", W'(busy[k]), W'(active[k]));
        chk("done", W'(done[k]), W'(done_exp[k]));
        if (issuing[k]) chk("tw_addr", W'(ta[k]), W'(grpm[k]));
        if (eov) begin
          chk("out_real", outr[k], qr[k][hd]);
          chk("out_imag", outi[k], qi[k][hd]);
          chk("out_last", W'(out_last[k]), W'(ql[k][hd]));
        end
        if (out_valid[k] && out_ready) obs_pops[k]++;
        ndone[k] += int'(done[k]);
        if (start[k] && !active[k]) begin
          active[k] = 1; issuing[k] = 1; grpm[k] = 0;
        end
        if (done_exp[k]) begin
          active[k] = 0; done_exp[k] = 0;
        end
        if (in_valid && erdy) begin
          qr[k][qt[k] % 16] = in_real;
          qi[k][qt[k] % 16] = exp_im(in_imag, grpm[k]);
          ql[k][qt[k] % 16] = grpm[k] == ng - 1;
          qa[k][qt[k] % 16] = cyc + 1;
          qt[k]++; acc[k]++; grpm[k]++;
          if (grpm[k] == ng) issuing[k] = 0;
        end
        if (eov && out_ready) begin
          if (ql[k][hd]) done_exp[k] = 1;
          qh[k]++; pops[k]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask
  task automatic run_until_done(int k, bit rv, bit rr);
    bit got = 0;
    for (int c = 0; c < 600 && !got; c++) begin
      in_valid  = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      in_real   = rnd();
      in_imag   = rnd();
      out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      got = done[k];
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL frame_done: inst %0d got no done pulse within budget", k);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, n, p, d, w;
    bit found;
    logic [W-1:0] hold;
    vt[0] = '{36'h123456789, 36'h000000001, 36'h123456789, exp_im(36'h000000001, 0), 1'b0};
    vt[1] = '{36'hFFFFFFFFF, 36'h800000000, 36'hFFFFFFFFF, exp_im(36'h800000000, 1), 1'b0};
    vt[2] = '{36'h000000000, 36'hFFFFFFFFF, 36'h000000000, exp_im(36'hFFFFFFFFF, 2), 1'b0};
    vt[3] = '{36'hA5A5A5A5A, 36'h02468ACE0, 36'hA5A5A5A5A, exp_im(36'h02468ACE0, 3), 1'b1};
    repeat (3) tick();
    rst = 1'b0;
    tick();
    // V1 + V6: back-to-back groups, fixed latency, table contents, twiddle addresses
    out_ready = 1'b1;
    pulse_start(0);
    a0 = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_real  = vt[i].ir;
      in_imag  = vt[i].ii;
      @(negedge clk);
      chk("v1_tw_addr", W'(ta[0]), W'(i));
      chk("v1_in_ready", W'(in_ready[0]), W'(1));
      tick();
      if (i == 0) a0 = cyc;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      found = 0;
      w = 0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        found = out_valid[0];
        if (!found) w++;
      end
      if (!found) begin
        total++; bad++;
        $display("FAIL v1_wait: output %0d never became valid", i);
      end else begin
        if (i == 0) chk("v1_latency", W'(cyc - a0), W'(LAT + 1));
        else chk("v1_consecutive", W'(w), '0);
        chk("v1_real", outr[0], vt[i].er);
        chk("v1_imag", outi[0], vt[i].ei);
        chk("v1_last", W'(out_last[0]), W'(vt[i].el));
      end
      tick();
    end
    @(negedge clk);
    chk("v1_done", W'(done[0]), W'(1));
    tick();
    @(negedge clk);
    chk("v1_done_once", W'(done[0]), '0);
    tick();
    // V2: full stall, entries held, then drained in order
    out_ready = 1'b0;
    p = obs_pops[0];
    pulse_start(0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_real = rnd();
      in_imag = rnd();
      @(negedge clk);
      chk("v2_in_ready", W'(in_ready[0]), W'(1));
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("v2_held_valid", W'(out_valid[0]), W'(1));
    hold = outr[0];
    repeat (5) tick();
    @(negedge clk);
    chk("v2_stall_hold", outr[0], hold);
    tick();
    run_until_done(0, 0, 0);
    chk("v2_outputs", W'(obs_pops[0] - p), W'(4));
    // V3: 16-group frame under backpressure, credit limit of FIFO_DEPTH
    out_ready = 1'b0;
    pulse_start(1);
    in_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      in_real = rnd();
      @(negedge clk);
      n += int'(in_valid && in_ready[1]);
      tick();
    end
    chk("v3_accepts", W'(n), W'(FD));
    @(negedge clk);
    chk("v3_no_credit", W'(in_ready[1]), '0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n += int'(in_ready[1]);
      tick();
    end
    chk("v3_one_per_pop", W'(n), W'(1));
    run_until_done(1, 1, 1);
    // V4: start pulses during ISSUE and DRAIN are ignored
    out_ready = 1'b1;
    p = obs_pops[0];
    d = ndone[0];
    pulse_start(0);
    in_valid = 1'b1;
    tick();
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    pulse_start(0);
    run_until_done(0, 0, 0);
    chk("v4_outputs", W'(obs_pops[0] - p), W'(4));
    chk("v4_one_done", W'(ndone[0] - d), W'(1));
    // V5: asynchronous reset mid-frame with buffered results
    out_ready = 1'b0;
    pulse_start(0);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("v5_pre_rst", W'({busy[0], out_valid[0]}), W'(3));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("v5_rst_async", W'({busy[0], out_valid[0], done[0]}), '0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    p = obs_pops[0];
    d = ndone[0];
    pulse_start(0);
    run_until_done(0, 0, 0);
    chk("v5_fresh_outputs", W'(obs_pops[0] - p), W'(4));
    chk("v5_one_done", W'(ndone[0] - d), W'(1));
    // Randomized frames with random valid/ready
    repeat (4) begin
      pulse_start(0);
      run_until_done(0, 1, 1);
    end
    pulse_start(1);
    run_until_done(1, 1, 1);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
